// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and FIFO write-port bundle between N producers, the arbiter and sync_fifo.
// The arbiter uses the slave view; the producer/FIFO environment uses the master view.
interface fifo_wr_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 16
);
  localparam int IW = $clog2(N);

  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [IW-1:0]   grant_id;
  logic            busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among N producers, granting
// bounded bursts of up to MAX_BURST beats with zero-cycle, full-aware transfers.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0] cand_idx, gnt_idx;
  logic          cand_found;
  logic [N-1:0]  ready;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    return (int'(idx) == N - 1) ? '0 : idx + 1'b1;
  endfunction

  // Scan downward so the lowest offset from rr_ptr_q is the one left standing.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_ptr_q) + k) % N]) begin
        cand_found = 1'b1;
        cand_idx   = IW'((int'(rr_ptr_q) + k) % N);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    ready      = '0;
    gnt_idx    = owner_q;
    case (state_q)
      IDLE: begin
        if (cand_found) begin
          gnt_idx = cand_idx;
          if (!bus.fifo_full) begin
            ready[cand_idx] = 1'b1;
            owner_d         = cand_idx;
            if (MAX_BURST > 1) begin
              state_d    = BURST;
              beat_cnt_d = BW'(1);
            end else begin
              rr_ptr_d = wrap_inc(cand_idx);
            end
          end
        end
      end
      BURST: begin
        if (!bus.req_valid[owner_q]) begin
          // Owner went quiet: release with a bubble, no transfer this cycle.
          state_d    = IDLE;
          rr_ptr_d   = wrap_inc(owner_q);
          beat_cnt_d = '0;
        end else if (!bus.fifo_full) begin
          ready[owner_q] = 1'b1;
          if (beat_cnt_q == BW'(MAX_BURST - 1)) begin
            state_d    = IDLE;
            rr_ptr_d   = wrap_inc(owner_q);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Reset also masks the combinational handshake so nothing is written while it is held.
  assign bus.req_ready  = rst ? '0 : ready;
  assign bus.fifo_wr_en = |(bus.req_valid & bus.req_ready);
  assign bus.fifo_din   = bus.req_data[int'(gnt_idx)*DW +: DW];
  assign bus.grant_id   = rst ? '0 : gnt_idx;
  assign bus.busy       = (state_q == BURST);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: burst, contention, stall, release, reset and a
// depth-8 FIFO model with a random reader checked by a per-requester scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;

  typedef struct {
    logic [1:0]  gid;
    logic [15:0] din;
    logic        busy;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N(N), .DW(DW)) a4 ();
  fifo_wr_arbiter_if #(.N(N), .DW(DW)) a1 ();

  fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(4)) dut  (.clk(clk), .rst(rst), .bus(a4));
  fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(a1));

  int checks   = 0;
  int failures = 0;
  int viol     = 0;
  int cyc      = 0;

  logic        use1     = 1'b0;
  logic        full_ctl = 1'b0;
  logic        model_en = 1'b0;
  logic [15:0] src [N][$];
  logic [15:0] fq [$];
  wr_t         wlog [$];

  logic [N-1:0] s_ready;
  logic         s_wr;
  logic [15:0]  s_din;
  logic [1:0]   s_gid;
  logic         s_busy;
  logic         last_rd_v;
  logic [15:0]  last_rd_w;

  // One clock of the environment: drive at posedge+1, sample at negedge, retire at posedge.
  task automatic cycle();
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    logic [N-1:0]    acc;
    logic            full_now;
    logic            do_rd;
    v = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (src[i].size() > 0) begin
        v[i]          = 1'b1;
        d[i*DW +: DW] = src[i][0];
      end
    end
    full_now = model_en ? (fq.size() >= 8) : full_ctl;
    if (use1) begin
      a1.req_valid = v;  a1.req_data = d;
      a4.req_valid = '0; a4.req_data = '0;
    end else begin
      a4.req_valid = v;  a4.req_data = d;
      a1.req_valid = '0; a1.req_data = '0;
    end
    a4.fifo_full = full_now;
    a1.fifo_full = full_now;
    @(negedge clk);
    s_ready = use1 ? a1.req_ready  : a4.req_ready;
    s_wr    = use1 ? a1.fifo_wr_en : a4.fifo_wr_en;
    s_din   = use1 ? a1.fifo_din   : a4.fifo_din;
    s_gid   = use1 ? a1.grant_id   : a4.grant_id;
    s_busy  = use1 ? a1.busy       : a4.busy;
    if (s_wr && full_now) viol++;
    if ($countones(s_ready) > 1) viol++;
    if (s_wr) wlog.push_back('{s_gid, s_din, s_busy, cyc});
    acc   = v & s_ready;
    do_rd = model_en && (fq.size() > 0) && ($urandom_range(0, 2) == 0);
    @(posedge clk);
    for (int i = 0; i < N; i++) if (acc[i]) void'(src[i].pop_front());
    last_rd_v = do_rd;
    if (do_rd) last_rd_w = fq.pop_front();
    if (model_en && s_wr) fq.push_back(s_din);
    cyc++;
    #1;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int b = 0;
    while (wlog.size() < n && b < budget) begin
      cycle();
      b++;
    end
    checks++;
    if (wlog.size() < n) begin
      failures++;
      $display("FAIL %s_timeout: writes=%0d expected=%0d", name, wlog.size(), n);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) src[i].delete();
    full_ctl = 1'b0;
    model_en = 1'b0;
    use1     = 1'b0;
    rst      = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    wlog.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) src[i].push_back(16'(16'h1000 * i));
    rst      = 1'b1;
    full_ctl = 1'b0;
    cycle();
    checks++; if (s_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", s_ready); end
    checks++; if (s_wr !== 1'b0)       begin failures++; $display("FAIL reset_wr_en: got %b want 0", s_wr); end
    checks++; if (s_gid !== 2'd0)      begin failures++; $display("FAIL reset_grant_id: got %0d want 0", s_gid); end
    checks++; if (s_busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b want 0", s_busy); end
  endtask

  task automatic test_single();
    do_reset();
    for (int s = 0; s < 6; s++) src[2].push_back(16'(16'hA000 + s));
    run_until(6, 40, "single");
    if (wlog.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (wlog[k].gid !== 2'd2 || wlog[k].din !== 16'(16'hA000 + k)) begin
          failures++;
          $display("FAIL single_word%0d: got id=%0d data=%h want id=2 data=%h", k, wlog[k].gid, wlog[k].din, 16'(16'hA000 + k));
        end
      end
      checks++; if (wlog[0].busy !== 1'b0) begin failures++; $display("FAIL single_first_busy: got %b want 0", wlog[0].busy); end
      checks++; if (wlog[1].busy !== 1'b1) begin failures++; $display("FAIL single_burst_busy: got %b want 1", wlog[1].busy); end
      checks++; if (wlog[4].busy !== 1'b0) begin failures++; $display("FAIL single_regrant_busy: got %b want 0", wlog[4].busy); end
      checks++;
      if (wlog[5].cyc - wlog[0].cyc !== 5) begin
        failures++;
        $display("FAIL single_span: got %0d cycles want 5", wlog[5].cyc - wlog[0].cyc);
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < N; i++)
      for (int s = 0; s < 5; s++) src[i].push_back(16'(i * 4096 + s));
    run_until(17, 60, "contention");
    if (wlog.size() >= 17) begin
      for (int k = 0; k < 17; k++) begin
        int eg;
        int es;
        eg = (k / 4) % 4;
        es = (k / 16) * 4 + k % 4;
        checks++;
        if (wlog[k].gid !== 2'(eg) || wlog[k].din !== 16'(eg * 4096 + es)) begin
          failures++;
          $display("FAIL contention_word%0d: got id=%0d data=%h want id=%0d data=%h", k, wlog[k].gid, wlog[k].din, eg, 16'(eg * 4096 + es));
        end
      end
      checks++;
      if (wlog[16].cyc - wlog[0].cyc !== 16) begin
        failures++;
        $display("FAIL contention_span: got %0d cycles want 16", wlog[16].cyc - wlog[0].cyc);
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    for (int s = 0; s < 6; s++) src[1].push_back(16'(16'hB000 + s));
    run_until(2, 20, "stall_pre");
    full_ctl = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if ({s_wr, s_ready[1], s_busy} !== 3'b001) begin
        failures++;
        $display("FAIL stall_cycle%0d: got wr_en=%b ready1=%b busy=%b want 0 0 1", c, s_wr, s_ready[1], s_busy);
      end
    end
    full_ctl = 1'b0;
    run_until(5, 20, "stall_post");
    if (wlog.size() >= 5) begin
      checks++;
      if (wlog[2].cyc - wlog[1].cyc !== 4) begin
        failures++;
        $display("FAIL stall_gap: got %0d cycles want 4", wlog[2].cyc - wlog[1].cyc);
      end
      checks++; if (wlog[3].busy !== 1'b1) begin failures++; $display("FAIL stall_beat4_busy: got %b want 1", wlog[3].busy); end
      checks++; if (wlog[4].busy !== 1'b0) begin failures++; $display("FAIL stall_regrant_busy: got %b want 0", wlog[4].busy); end
      checks++;
      if (wlog[4].din !== 16'hB004 || wlog[4].cyc - wlog[3].cyc !== 1) begin
        failures++;
        $display("FAIL stall_regrant: got data=%h gap=%0d want data=b004 gap=1", wlog[4].din, wlog[4].cyc - wlog[3].cyc);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    src[1].push_back(16'hC100); src[1].push_back(16'hC101);
    src[3].push_back(16'hC300); src[3].push_back(16'hC301);
    run_until(4, 20, "release");
    if (wlog.size() >= 4) begin
      checks++;
      if (wlog[0].gid !== 2'd1 || wlog[1].gid !== 2'd1 || wlog[2].gid !== 2'd3 || wlog[3].gid !== 2'd3) begin
        failures++;
        $display("FAIL release_order: got ids %0d %0d %0d %0d want 1 1 3 3", wlog[0].gid, wlog[1].gid, wlog[2].gid, wlog[3].gid);
      end
      checks++;
      if (wlog[2].cyc - wlog[1].cyc !== 2) begin
        failures++;
        $display("FAIL release_bubble: got gap %0d want 2", wlog[2].cyc - wlog[1].cyc);
      end
      checks++;
      if (wlog[2].din !== 16'hC300 || wlog[2].busy !== 1'b0) begin
        failures++;
        $display("FAIL release_regrant: got data=%h busy=%b want c300 0", wlog[2].din, wlog[2].busy);
      end
    end
  endtask

  task automatic test_max_burst_one();
    logic [15:0] exp_d [6];
    exp_d = '{16'hD000, 16'hD300, 16'hD001, 16'hD301, 16'hD002, 16'hD302};
    do_reset();
    use1 = 1'b1;
    for (int s = 0; s < 3; s++) begin
      src[0].push_back(16'(16'hD000 + s));
      src[3].push_back(16'(16'hD300 + s));
    end
    run_until(6, 20, "mb1");
    if (wlog.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (wlog[k].din !== exp_d[k] || wlog[k].gid !== ((k % 2 == 0) ? 2'd0 : 2'd3) || wlog[k].busy !== 1'b0) begin
          failures++;
          $display("FAIL mb1_word%0d: got id=%0d data=%h busy=%b want data=%h busy=0", k, wlog[k].gid, wlog[k].din, wlog[k].busy, exp_d[k]);
        end
      end
      checks++;
      if (wlog[5].cyc - wlog[0].cyc !== 5) begin
        failures++;
        $display("FAIL mb1_span: got %0d cycles want 5", wlog[5].cyc - wlog[0].cyc);
      end
    end
    use1 = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int s = 0; s < 6; s++) src[1].push_back(16'(16'hF100 + s));
    run_until(5, 30, "midrst_pre");
    src[0].push_back(16'hF000);
    src[2].push_back(16'hF200);
    rst = 1'b1;
    cycle();
    checks++; if (s_ready !== 4'b0000) begin failures++; $display("FAIL midrst_ready: got %b want 0000", s_ready); end
    checks++; if (s_wr !== 1'b0)       begin failures++; $display("FAIL midrst_wr_en: got %b want 0", s_wr); end
    checks++; if (s_busy !== 1'b0)     begin failures++; $display("FAIL midrst_busy: got %b want 0", s_busy); end
    checks++; if (s_gid !== 2'd0)      begin failures++; $display("FAIL midrst_grant_id: got %0d want 0", s_gid); end
    cycle();
    rst = 1'b0;
    wlog.delete();
    run_until(1, 10, "midrst_post");
    if (wlog.size() >= 1) begin
      checks++;
      if (wlog[0].gid !== 2'd0 || wlog[0].din !== 16'hF000) begin
        failures++;
        $display("FAIL midrst_priority: got id=%0d data=%h want id=0 data=f000", wlog[0].gid, wlog[0].din);
      end
    end
  endtask

  task automatic test_integration();
    int exp_seq [N];
    int reads;
    int b;
    int id;
    do_reset();
    fq.delete();
    model_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_seq[i] = 0;
      for (int s = 0; s < 10; s++) src[i].push_back(16'(i * 4096 + s));
    end
    reads = 0;
    b     = 0;
    while (reads < 40 && b < 3000) begin
      cycle();
      b++;
      if (last_rd_v) begin
        reads++;
        id = int'(last_rd_w[15:12]);
        checks++;
        if (id >= N) begin
          failures++;
          $display("FAIL integ_source: got word %h with unknown requester", last_rd_w);
        end else begin
          if (int'(last_rd_w[11:0]) !== exp_seq[id]) begin
            failures++;
            $display("FAIL integ_order_r%0d: got seq %0d want %0d", id, last_rd_w[11:0], exp_seq[id]);
          end
          exp_seq[id] = int'(last_rd_w[11:0]) + 1;
        end
      end
    end
    checks++;
    if (reads !== 40) begin failures++; $display("FAIL integ_count: got %0d reads want 40", reads); end
    checks++;
    if (fq.size() !== 0) begin failures++; $display("FAIL integ_leftover: got %0d words want 0", fq.size()); end
    model_en = 1'b0;
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL protocol_violations: got %0d want 0", viol); end
  endtask

  initial begin
    rst = 1'b1;
    a4.req_valid = '0; a4.req_data = '0; a4.fifo_full = 1'b0;
    a1.req_valid = '0; a1.req_data = '0; a1.fifo_full = 1'b0;
    last_rd_v = 1'b0;
    last_rd_w = '0;
    test_reset();
    test_single();
    test_contention();
    test_full_stall();
    test_early_release();
    test_max_burst_one();
    test_reset_mid_burst();
    test_integration();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
